// File: rtl/img_binarizer_if.sv
// Pixel-stream and image-handshake bundle between the pixel source, the
// binarizer and the downstream classifier.
interface img_binarizer_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic [PIX_W-1:0] threshold;
  logic [255:0]     test_image;
  logic             valid;
  logic             ack;
  logic             frame_err;
  logic [7:0]       frame_cnt;

  // Binarizer side
  modport slave (
    input  pix_in, pix_valid, pix_sof, threshold, ack,
    output pix_ready, test_image, valid, frame_err, frame_cnt
  );

  // Source / classifier side
  modport master (
    output pix_in, pix_valid, pix_sof, threshold, ack,
    input  pix_ready, test_image, valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/img_binarizer.sv
// 32x32 grayscale raster stream -> 2x2 block sums -> thresholded 16x16
// binary image, held on test_image/valid until the classifier acks.
module img_binarizer #(
  parameter int PIX_W   = 8,
  parameter int MIN_GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  img_binarizer_if.slave  bus
);
  localparam int SUM_W = PIX_W + 2;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [9:0]           idx_q, idx_d;
  logic [PIX_W-1:0]     thr_q, thr_d;
  logic [PIX_W-1:0]     hold_px_q;
  logic [255:0]         work_q, work_d;
  logic [255:0]         img_q, img_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           cnt_q, cnt_d;

  // Row buffer of half-block sums, one cell per output column
  logic [16*SUM_W-1:0]  rb_flat;

  logic                 xfer;
  logic                 proc_en;
  logic [9:0]           proc_idx;
  logic                 x_odd, y_odd;
  logic [3:0]           col, row;
  logic [SUM_W-1:0]     pair_sum, block_sum;
  logic                 blk_bit;

  // Ready only while collecting; forced low while reset is asserted
  assign bus.pix_ready = !rst && (state_q == IDLE || state_q == COLLECT);
  assign xfer          = bus.pix_valid && bus.pix_ready;
  // In IDLE only a sof pixel starts a frame; everything else is dropped
  assign proc_en       = xfer && (state_q == COLLECT || bus.pix_sof);
  assign proc_idx      = bus.pix_sof ? 10'd0 : idx_q;

  assign x_odd = proc_idx[0];
  assign y_odd = proc_idx[5];
  assign col   = proc_idx[4:1];
  assign row   = proc_idx[9:6];

  // Horizontal pair sum, then full 2x2 sum using the stored upper pair
  assign pair_sum  = SUM_W'(hold_px_q) + SUM_W'(bus.pix_in);
  assign block_sum = rb_flat[col*SUM_W +: SUM_W] + pair_sum;
  // Comparing against 4*thr is the per-pixel threshold applied to the block mean
  assign blk_bit   = (block_sum >= {thr_q, 2'b00});

  // Next-state logic for the frame FSM and its datapath registers
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    thr_d       = thr_q;
    work_d      = work_q;
    img_d       = img_q;
    gap_d       = gap_q;
    frame_err_d = 1'b0;
    cnt_d       = cnt_q;

    if (proc_en) begin
      idx_d = proc_idx + 10'd1;
      if (bus.pix_sof) thr_d = bus.threshold;
      if (x_odd && y_odd) work_d[{row, col}] = blk_bit;
    end

    case (state_q)
      IDLE: begin
        if (proc_en) state_d = COLLECT;
      end
      COLLECT: begin
        // A sof here restarts the frame; partial data is simply overwritten
        if (xfer && bus.pix_sof) frame_err_d = 1'b1;
        if (proc_en && proc_idx == 10'd1023) begin
          img_d   = work_d;
          cnt_d   = cnt_q + 8'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(MIN_GAP - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      thr_q       <= '0;
      work_q      <= '0;
      img_q       <= '0;
      gap_q       <= '0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      thr_q       <= thr_d;
      work_q      <= work_d;
      img_q       <= img_d;
      gap_q       <= gap_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Even-x pixel waits here for its odd-x partner
  always_ff @(posedge clk) begin
    if (rst)                    hold_px_q <= '0;
    else if (proc_en && !x_odd) hold_px_q <= bus.pix_in;
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rb
      logic [SUM_W-1:0] cell_q;
      // Upper-row pair sum for column gi, written on even rows
      always_ff @(posedge clk) begin
        if (rst)
          cell_q <= '0;
        else if (proc_en && x_odd && !y_odd && col == 4'(gi))
          cell_q <= pair_sum;
      end
      assign rb_flat[gi*SUM_W +: SUM_W] = cell_q;
    end
  endgenerate

  assign bus.test_image = img_q;
  assign bus.valid      = (state_q == HOLD);
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = cnt_q;
endmodule

// File: tb/tb_img_binarizer.sv
// Self-checking bench for img_binarizer: table-driven block patterns,
// randomized frames against a block-average reference model, and
// hand-written sequences for restart, hold/ack and reset corner cases.
module tb_img_binarizer;
  localparam int MIN_GAP = 2;

  logic clk = 1'b0;
  logic rst;
  img_binarizer_if #(.PIX_W(8)) bus ();

  img_binarizer #(.PIX_W(8), .MIN_GAP(MIN_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ferr_pulses = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] pix [1024];

  typedef struct {
    int          thr;
    int          a;
    int          adec;
    int          b;
    int          bdec;
    logic [15:0] ev_row;
    logic [15:0] od_row;
  } vec_t;
  vec_t vecs [6];

  always @(negedge clk) if (bus.frame_err === 1'b1) ferr_pulses++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each output bit is 1 when the 2x2 block mean reaches thr
  function automatic logic [255:0] model_img(input int thr);
    logic [255:0] m;
    int s;
    m = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        s = int'(pix[64*r + 2*c]) + int'(pix[64*r + 2*c + 1])
          + int'(pix[64*r + 32 + 2*c]) + int'(pix[64*r + 32 + 2*c + 1]);
        m[16*r + c] = (s >= 4 * thr);
      end
    return m;
  endfunction

  function automatic logic [255:0] rows_img(input logic [15:0] ev, input logic [15:0] od);
    logic [255:0] m;
    for (int r = 0; r < 16; r++) m[16*r +: 16] = (r % 2 == 0) ? ev : od;
    return m;
  endfunction

  // Block (r,c) uses value a when r+c is even, else b; its bottom-right pixel is reduced by dec
  task automatic fill_pattern(input int a, input int adec, input int b, input int bdec);
    int v;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        v = (((y / 2) + (x / 2)) % 2 == 0) ? a : b;
        if ((y % 2 == 1) && (x % 2 == 1))
          v -= (((y / 2) + (x / 2)) % 2 == 0) ? adec : bdec;
        pix[y*32 + x] = 8'(v);
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) pix[i] = 8'($urandom_range(255));
  endtask

  // Present one pixel and wait until it is transferred; entered and left at posedge+1
  task automatic push(input logic [7:0] px, input logic sof);
    bit rdy;
    int n;
    bus.pix_in    = px;
    bus.pix_sof   = sof;
    bus.pix_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: pix_ready stayed 0 for %0d cycles, required 1", n);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  // Send pixels start..start+count-1 of pix[]; index 0 carries sof
  task automatic send_frame(input int start, input int count, input int thr, input int gap_pct);
    for (int i = start; i < start + count; i++) begin
      if (int'($urandom_range(99)) < gap_pct)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      bus.threshold = (i == 0) ? 8'(thr) : ~8'(thr);
      if (i == 1023) chk("valid_before_last", 256'(bus.valid), 256'(0));
      push(pix[i], i == 0);
    end
  endtask

  // Called right after the last-pixel edge: 1-cycle latency means valid is already up
  task automatic frame_done(input string name, input logic [255:0] exp_img);
    exp_cnt++;
    chk({name, "_valid"}, 256'(bus.valid), 256'(1));
    chk({name, "_image"}, bus.test_image, exp_img);
    chk({name, "_cnt"}, 256'(bus.frame_cnt), 256'(exp_cnt));
    $display("frame %s cnt=%0d image=%h", name, bus.frame_cnt, bus.test_image);
  endtask

  task automatic do_ack();
    int n;
    bit bad;
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    chk("ack_valid_drop", 256'(bus.valid), 256'(0));
    n = 0;
    bad = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) bad = 1'b1;
      if (bus.pix_ready === 1'b1) break;
      n++;
    end
    chk("gap_len", 256'(n), 256'(MIN_GAP));
    chk("gap_valid_low", 256'(bad), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, 256'(bus.valid), 256'(0));
    chk({name, "_image"}, bus.test_image, 256'(0));
    chk({name, "_ferr"}, 256'(bus.frame_err), 256'(0));
    chk({name, "_cnt"}, 256'(bus.frame_cnt), 256'(0));
  endtask

  initial begin
    logic [255:0] exp_img;
    logic [255:0] held;
    int thr, p0;

    vecs[0] = '{128, 255, 0, 255, 0, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{100, 200, 0,  50, 0, 16'h5555, 16'hAAAA};
    vecs[2] = '{100, 100, 0, 100, 1, 16'h5555, 16'hAAAA};
    vecs[3] = '{  0,   0, 0,   0, 0, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{255, 255, 0, 255, 1, 16'h5555, 16'hAAAA};
    vecs[5] = '{200, 199, 0, 201, 0, 16'hAAAA, 16'h5555};

    rst = 1'b1;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
    bus.threshold = '0; bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_ready", 256'(bus.pix_ready), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven block patterns including the threshold boundary
    for (int v = 0; v < 6; v++) begin
      fill_pattern(vecs[v].a, vecs[v].adec, vecs[v].b, vecs[v].bdec);
      send_frame(0, 1024, vecs[v].thr, 0);
      exp_img = rows_img(vecs[v].ev_row, vecs[v].od_row);
      frame_done($sformatf("vec%0d", v), exp_img);
      chk($sformatf("vec%0d_model", v), bus.test_image, model_img(vecs[v].thr));
      do_ack();
    end

    // sof mid-frame at index 500: only the second frame counts
    p0 = ferr_pulses;
    fill_random();
    send_frame(0, 500, 90, 0);
    fill_random();
    thr = 130;
    send_frame(0, 1, thr, 0);
    @(negedge clk);
    chk("restart_ferr", 256'(bus.frame_err), 256'(1));
    @(posedge clk);
    #1;
    send_frame(1, 1023, thr, 0);
    frame_done("restart", model_img(thr));
    chk("restart_ferr_once", 256'(ferr_pulses - p0), 256'(1));
    do_ack();

    // Ack and stray non-sof pixels in IDLE must be ignored
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    for (int k = 0; k < 5; k++) push(8'($urandom_range(255)), 1'b0);
    chk("idle_ignore_valid", 256'(bus.valid), 256'(0));

    // Random frame with input gaps, then a long hold with ack withheld
    fill_random();
    thr = int'($urandom_range(64, 191));
    send_frame(0, 1024, thr, 30);
    exp_img = model_img(thr);
    frame_done("rand_gap", exp_img);
    held = bus.test_image;
    for (int k = 0; k < 50; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_sof   = 1'b1;
      bus.pix_in    = 8'($urandom_range(255));
      @(negedge clk);
      chk("hold_valid", 256'(bus.valid), 256'(1));
      chk("hold_image", bus.test_image, exp_img);
      chk("hold_ready", 256'(bus.pix_ready), 256'(0));
      @(posedge clk);
      #1;
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    chk("hold_cnt", 256'(bus.frame_cnt), 256'(exp_cnt));
    do_ack();
    chk("gap_image_kept", bus.test_image, held);

    fill_random();
    thr = int'($urandom_range(64, 191));
    send_frame(0, 1024, thr, 20);
    frame_done("rand_next", model_img(thr));
    do_ack();

    // Reset at index 700, then a clean frame
    fill_random();
    send_frame(0, 700, 120, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_collect_ready", 256'(bus.pix_ready), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 8'd0;
    check_reset_outputs("rst_collect");
    fill_random();
    thr = int'($urandom_range(64, 191));
    send_frame(0, 1024, thr, 10);
    frame_done("after_rst1", model_img(thr));

    // Reset while holding, then a clean frame
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 8'd0;
    check_reset_outputs("rst_hold");
    fill_pattern(200, 0, 50, 0);
    send_frame(0, 1024, 100, 10);
    frame_done("after_rst2", rows_img(16'h5555, 16'hAAAA));
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end
endmodule
